// File: rtl/adder_pkg.sv
// Shared constants and types for the registered carry-lookahead adder.
// The result type packs {cout, s} so models can compare against a single (WIDTH+1)-bit value.
package adder_pkg;

  localparam int ADDER_WIDTH = 6;

  typedef logic [ADDER_WIDTH:0] sum_t;

endpackage : adder_pkg

// File: rtl/cla_block_4b.sv
// 4-bit carry-lookahead block: produces the carries into each bit position
// plus block generate/propagate, so blocks can be chained by the parent.
module cla_block_4b (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       bg,
  output logic       bp
);

  // c[i] is the carry into bit i of this block; c[0] is simply the block carry-in.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign bp = &p;

endmodule : cla_block_4b

// File: rtl/adder_6b.sv
// Registered unsigned adder: {cout,s} = x + y one clock after in_valid.
// Core is generate/propagate cells feeding 4-bit lookahead blocks that ripple block-to-block.
module adder_6b
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  localparam int NBLK = (WIDTH + 3) / 4;
  localparam int PW   = NBLK * 4;

  logic [PW-1:0]    g_ext;
  logic [PW-1:0]    p_ext;
  logic [PW-1:0]    c_vec;
  logic [NBLK-1:0]  bg_vec;
  logic [NBLK-1:0]  bp_vec;
  logic [NBLK-1:0]  bcin_vec;
  logic             blk_cout;
  logic [WIDTH-1:0] sum_comb;
  logic             cout_comb;

  // Bits above WIDTH in the last block are tied off so they neither generate nor propagate.
  always_comb begin
    g_ext              = '0;
    p_ext              = '0;
    g_ext[WIDTH-1:0]   = x & y;
    p_ext[WIDTH-1:0]   = x ^ y;
  end

  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    cla_block_4b u_blk (
      .g   (g_ext[4*b +: 4]),
      .p   (p_ext[4*b +: 4]),
      .cin (bcin_vec[b]),
      .c   (c_vec[4*b +: 4]),
      .bg  (bg_vec[b]),
      .bp  (bp_vec[b])
    );
  end

  // Ripple between blocks: each block's carry-in is the previous block's carry-out.
  always_comb begin
    bcin_vec = '0;
    blk_cout = 1'b0;
    for (int b = 0; b < NBLK; b++) begin
      bcin_vec[b] = blk_cout;
      blk_cout    = bg_vec[b] | (bp_vec[b] & blk_cout);
    end
  end

  assign sum_comb = p_ext[WIDTH-1:0] ^ c_vec[WIDTH-1:0];

  // When WIDTH is not a multiple of 4 the true carry-out is an internal carry of the last block.
  if (PW == WIDTH) begin : g_cout_blk
    assign cout_comb = blk_cout;
  end else begin : g_cout_int
    assign cout_comb = c_vec[WIDTH];
  end

  // Carries past bit WIDTH and the last block's lookahead terms only exist to fill the block.
  logic unused_sink;
  assign unused_sink = ^{c_vec, bg_vec, bp_vec, blk_cout};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_comb;
        cout <= cout_comb;
      end
    end
  end

endmodule : adder_6b

// File: tb/tb_adder_6b.sv
// Self-checking bench for adder_6b: directed boundary/hold/reset steps plus an
// exhaustive back-to-back sweep, with expected sums held in a scoreboard queue.
module tb_adder_6b;
  import adder_pkg::*;

  localparam int W = ADDER_WIDTH;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;

  int   n_checks;
  int   n_fail;
  sum_t exp_q[$];
  sum_t held;

  adder_6b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus, then compare right after the capturing edge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    sum_t exp_sum;
    @(negedge clk);
    in_valid = v;
    x        = a;
    y        = b;
    if (v) exp_q.push_back(sum_t'(a) + sum_t'(b));
    @(posedge clk);
    #1;
    if (v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s: scoreboard empty, observed=%0d expected=entry", tag, {cout, s});
      end else begin
        exp_sum = exp_q.pop_front();
        held    = exp_sum;
        check({tag, ".sum"}, 32'({cout, s}), 32'(exp_sum));
      end
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
    end else begin
      check({tag, ".hold"}, 32'({cout, s}), 32'(held));
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    held     = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;

    #12;
    check("rst_init.sum",   32'({cout, s}), 32'd0);
    check("rst_init.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boundaries and full-pattern operands.
    step("zero",      1'b1, 6'd0,  6'd0);
    step("wrap",      1'b1, 6'd63, 6'd1);
    step("max_max",   1'b1, 6'd63, 6'd63);
    step("alt_bits",  1'b1, 6'd21, 6'd42);
    step("msb_carry", 1'b1, 6'd32, 6'd32);

    // Hold: a registered result survives idle cycles with changing operands.
    step("hold_load", 1'b1, 6'd10, 6'd20);
    for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 1'b0, 6'd1, 6'd1);

    // Reset asserted mid-cycle with a valid input pending.
    @(negedge clk);
    in_valid = 1'b1;
    x        = 6'd5;
    y        = 6'd7;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.sum",   32'({cout, s}), 32'd0);
    check("rst_mid.valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge.sum",   32'({cout, s}), 32'd0);
    check("rst_edge.valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    held = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 6'd5, 6'd7);

    // Exhaustive sweep, back-to-back with no idle cycles.
    for (int i = 0; i < (1 << (2 * W)); i++) begin
      step($sformatf("exh[%0d]", i), 1'b1, W'(i >> W), W'(i));
    end

    @(negedge clk);
    in_valid = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder_6b

// File: doc/adder_6b.md
Name: adder_6b

Overview:
- Registered unsigned binary adder: two WIDTH-bit operands in, WIDTH-bit sum plus carry-out, one clock of latency.
- Default WIDTH=6: exhaustive verification over all 64x64 = 4096 operand pairs is practical.
- Sits in the arithmetic datapath; purely datapath, no control beyond a valid strobe.

Parameters:
- WIDTH, 6, operand and sum width in bits (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x/y presented this cycle are to be added.
- x  input  WIDTH  unsigned operand A.
- y  input  WIDTH  unsigned operand B.
- s  output  WIDTH  registered sum bits, (x+y) mod 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of x+y.
- out_valid  output  1  s/cout hold a result computed from an accepted input.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, s=0, cout=0, out_valid=0 immediately, regardless of clk.
- Release of reset takes effect on the first rising clk edge with rst_n=1.
- Arithmetic: {cout,s} = x + y as an unsigned (WIDTH+1)-bit result.
  - No carry-in.
  - No signed overflow flag.
  - cout=1 exactly when x+y >= 2^WIDTH.
- Latency: on a rising edge with in_valid=1, s/cout capture the sum of the x/y sampled at that edge, and out_valid<=1.
- On a rising edge with in_valid=0: s/cout hold their previous values, and out_valid<=0.
- Throughput: one addition per cycle; back-to-back in_valid is fully supported with no bubbles.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 until a new in_valid edge after release.
- Combinational core:
  - Carry-lookahead structure built from 1-bit generate/propagate cells, grouped in 4-bit lookahead blocks, with ripple between blocks.
  - Must meet timing as a single-cycle path.
  - Behavioural '+' is not used for the core; the result must equal x+y for all operand pairs.
- Wrap-around: (2^WIDTH-1)+1 gives s=0, cout=1.
- X-handling: outputs are never X after reset when the inputs are known.

Decomposition:
- Shared package adder_pkg holds:
  - the default WIDTH constant;
  - a typedef for the WIDTH+1-bit result {cout,s}, used by the bench model.
- One sub-module: cla_block_4b.
  - Inputs: 4-bit generate/propagate and carry-in.
  - Outputs: internal carries, block generate/propagate.
  - Instantiated ceil(WIDTH/4) times.
  - Unused upper bits of the last block are tied to zero.
- Top level holds the generate/propagate cells, the block chaining, the sum XORs and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in_valid=1, x=5, y=7 -> s=0, cout=0, out_valid=0 immediately; after release, x=5, y=7, in_valid=1 -> next edge s=12, cout=0, out_valid=1.
- Boundaries:
  - x=0, y=0 -> s=0, cout=0.
  - x=63, y=1 -> s=0, cout=1.
  - x=63, y=63 -> s=62 (111110), cout=1.
- No-carry full pattern: x=21 (010101), y=42 (101010) -> s=63, cout=0; x=32, y=32 -> s=0, cout=1.
- Hold: result x=10, y=20 (s=30) registered, then in_valid=0 with x=1, y=1 for 3 cycles -> s stays 30, out_valid=0.
- Exhaustive: all 4096 (x,y) pairs back-to-back with in_valid=1 -> each cycle {cout,s} equals the previous cycle's x+y.
  - Bench counts mismatches, reports each failing index, and requires zero errors.
